up_down_counter_param: RTL

//  Parametrised synchronous up/down counter; the general-width successor of the

---
 rtl/up_down_counter_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/up_down_counter_param.sv
// -----------------------------------------------------------------------------
// up_down_counter_param
// Parametrised up/down counter with count enable, parallel load (clamped to
// MAX_VAL), programmable modulus, wrap or saturate behaviour at the
// boundaries, a combinational terminal-count strobe and a sticky boundary
// flag. The counter value never leaves the range 0..MAX_VAL.
// -----------------------------------------------------------------------------
module up_down_counter_param #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL  = {WIDTH{1'b1}},
  parameter bit                 SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             boundary_flag
);

  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] counter_r;
  logic             flag_r;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic [WIDTH-1:0] counter_next_s;
  logic             flag_next_s;

  // Boundary detection and terminal-count strobe from registered state and inputs.
  always_comb begin
    at_max_s = (counter_r == MAX_VAL);
    at_min_s = (counter_r == ZERO_VAL);
    tc_s     = reset & ~load & en & ((~x & at_max_s) | (x & at_min_s));
  end

  // Clamp oversize load values so the counter never leaves 0..MAX_VAL.
  always_comb begin
    load_clamped_s = load_value;
    if (load_value > MAX_VAL) begin
      load_clamped_s = MAX_VAL;
    end else begin
      load_clamped_s = load_value;
    end
  end

  // Next counter value: load has priority over counting, counting over hold.
  always_comb begin
    counter_next_s = counter_r;
    if (load) begin
      counter_next_s = load_clamped_s;
    end else if (en) begin
      if (!x) begin
        if (at_max_s) begin
          if (SATURATE) begin
            counter_next_s = MAX_VAL;
          end else begin
            counter_next_s = ZERO_VAL;
          end
        end else begin
          counter_next_s = counter_r + ONE_VAL;
        end
      end else begin
        if (at_min_s) begin
          if (SATURATE) begin
            counter_next_s = ZERO_VAL;
          end else begin
            counter_next_s = MAX_VAL;
          end
        end else begin
          counter_next_s = counter_r - ONE_VAL;
        end
      end
    end else begin
      counter_next_s = counter_r;
    end
  end

  // Sticky flag: a boundary step sets it and beats a simultaneous clear.
  always_comb begin
    flag_next_s = flag_r;
    if (tc_s) begin
      flag_next_s = 1'b1;
    end else if (clr_flag) begin
      flag_next_s = 1'b0;
    end else begin
      flag_next_s = flag_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_r <= ZERO_VAL;
      flag_r    <= 1'b0;
    end else begin
      counter_r <= counter_next_s;
      flag_r    <= flag_next_s;
    end
  end

  assign counter       = counter_r;
  assign tc            = tc_s;
  assign boundary_flag = flag_r;

endmodule
